// File: rtl/dac_out_pkg.sv
// Shared constants and codes for the DAC output stage and its lane scaler.
package dac_out_pkg;

    localparam int DAC_NUM_SAMPLES  = 8;
    localparam int DAC_SAMPLE_WIDTH = 16;
    localparam int DAC_RAMP_BITS    = 10;

    // Q1.15 unity gain and the half-LSB added before the >>15 in S3
    localparam logic [15:0] DAC_GAIN_UNITY  = 16'h8000;
    localparam int          DAC_ROUND_CONST = 'h4000;

    typedef enum logic [1:0] {
        RS_MUTED     = 2'd0,
        RS_RAMP_UP   = 2'd1,
        RS_ACTIVE    = 2'd2,
        RS_RAMP_DOWN = 2'd3
    } ramp_state_t;

    typedef enum logic [1:0] {
        PAT_DATA = 2'd0,
        PAT_ZERO = 2'd1,
        PAT_DC   = 2'd2,
        PAT_SAW  = 2'd3
    } pattern_t;

endpackage

// File: rtl/dac_lane_scaler.sv
// One output lane: S2 multiply by the ramped scale, S3 round half up,
// saturate and register. Clip is combinational so the top can fold it into
// the sticky flag on the same edge the saturated sample is registered.
module dac_lane_scaler
    import dac_out_pkg::*;
#(
    parameter int W = DAC_SAMPLE_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] sample,
    input  logic        [W-1:0] scale,
    output logic        [W-1:0] sample_out,
    output logic                clip
);

    // signed W x unsigned W needs one extra bit to hold the full product
    localparam int PW = 2 * W + 1;
    localparam logic signed [PW-1:0] ROUND   = PW'(DAC_ROUND_CONST);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] shifted;
    logic        [W-1:0]  sat_c;
    logic                 clip_c;

    // zero-extend scale so the multiply treats it as unsigned
    assign prod_c  = sample * $signed({1'b0, scale});
    assign rnd     = prod_q + ROUND;
    assign shifted = rnd >>> (W - 1);

    // S2: register the product
    always_ff @(posedge clock or posedge reset) begin
        if (reset) prod_q <= '0;
        else       prod_q <= prod_c;
    end

    // S3 combinational: clamp the rounded value to the signed sample range
    always_comb begin
        sat_c  = shifted[W-1:0];
        clip_c = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_c  = SAT_MAX[W-1:0];
            clip_c = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_c  = SAT_MIN[W-1:0];
            clip_c = 1'b1;
        end
    end

    // S3: register the saturated sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sample_out <= '0;
        else       sample_out <= sat_c;
    end

    assign clip = clip_c;

endmodule

// File: rtl/dac_output_stage.sv
// Final stage for one RF-DAC channel: pattern select, gain, soft mute ramp,
// round and saturate across NUM_SAMPLES lanes, fixed 3-clock latency.
module dac_output_stage
    import dac_out_pkg::*;
#(
    parameter int NUM_SAMPLES  = DAC_NUM_SAMPLES,
    parameter int SAMPLE_WIDTH = DAC_SAMPLE_WIDTH,
    parameter int RAMP_BITS    = DAC_RAMP_BITS
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [1:0]                          pattern_sel,
    input  logic [SAMPLE_WIDTH-1:0]             dc_value,
    input  logic [SAMPLE_WIDTH-1:0]             gain,
    input  logic                                clip_clear,
    input  logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0] dac_data_in,
    output logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0] dac_data_out,
    output logic [1:0]                          ramp_state,
    output logic                                clip_flag
);

    localparam logic [RAMP_BITS:0] LEVEL_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [RAMP_BITS:0] LEVEL_ONE  = {{RAMP_BITS{1'b0}}, 1'b1};

    ramp_state_t                                state_q, state_d;
    logic [RAMP_BITS:0]                         level_q, level_d;
    logic [SAMPLE_WIDTH+RAMP_BITS:0]            gain_x_level;
    logic [SAMPLE_WIDTH-1:0]                    scale_q;
    logic [SAMPLE_WIDTH-1:0]                    cnt_q;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0]   din_lanes;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0]   pat_lanes;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0]   s1_q;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0]   lane_out;
    logic [NUM_SAMPLES-1:0]                     lane_clip;
    logic                                       unused_scale_bits;

    assign din_lanes    = dac_data_in;
    assign dac_data_out = lane_out;
    assign ramp_state   = state_q;

    // Ramp state and level register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RS_MUTED;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // Ramp next-state: reversals keep the current level so the output never steps.
    // A reversal that lands on an end point goes straight to the settled state
    // so the level can never run past 0 or FULL.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            RS_MUTED: begin
                level_d = '0;
                if (enable) state_d = RS_RAMP_UP;
            end
            RS_RAMP_UP: begin
                if (!enable) begin
                    state_d = (level_q == '0) ? RS_MUTED : RS_RAMP_DOWN;
                end else begin
                    level_d = level_q + LEVEL_ONE;
                    if (level_q == LEVEL_FULL - LEVEL_ONE) state_d = RS_ACTIVE;
                end
            end
            RS_ACTIVE: begin
                level_d = LEVEL_FULL;
                if (!enable) state_d = RS_RAMP_DOWN;
            end
            RS_RAMP_DOWN: begin
                if (enable) begin
                    state_d = (level_q == LEVEL_FULL) ? RS_ACTIVE : RS_RAMP_UP;
                end else begin
                    level_d = level_q - LEVEL_ONE;
                    if (level_q == LEVEL_ONE) state_d = RS_MUTED;
                end
            end
            default: begin
                state_d = RS_MUTED;
                level_d = '0;
            end
        endcase
    end

    // gain * level / 2^RAMP_BITS; at FULL this is exactly gain, so the top bit
    // and the fractional bits are never needed
    assign gain_x_level      = gain * level_q;
    assign unused_scale_bits = ^{gain_x_level[SAMPLE_WIDTH+RAMP_BITS], gain_x_level[RAMP_BITS-1:0]};

    // Scale register, refreshed every clock from the pre-edge level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) scale_q <= '0;
        else       scale_q <= gain_x_level[RAMP_BITS +: SAMPLE_WIDTH];
    end

    // Sawtooth base advances every clock whatever pattern is selected
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + SAMPLE_WIDTH'(NUM_SAMPLES);
    end

    // Pattern mux feeding S1
    always_comb begin
        pat_lanes = din_lanes;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            case (pattern_t'(pattern_sel))
                PAT_ZERO: pat_lanes[k] = '0;
                PAT_DC:   pat_lanes[k] = dc_value;
                PAT_SAW:  pat_lanes[k] = cnt_q + SAMPLE_WIDTH'(k);
                default:  pat_lanes[k] = din_lanes[k];
            endcase
        end
    end

    // S1: registered pattern word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) s1_q <= '0;
        else       s1_q <= pat_lanes;
    end

    for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_lane
        dac_lane_scaler #(
            .W (SAMPLE_WIDTH)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .sample     (s1_q[k]),
            .scale      (scale_q),
            .sample_out (lane_out[k]),
            .clip       (lane_clip[k])
        );
    end

    // Sticky clip: a saturating lane beats a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) clip_flag <= 1'b0;
        else       clip_flag <= (|lane_clip) | (clip_flag & ~clip_clear);
    end

endmodule
